// File: rtl/slot_arbiter_pkg.sv
// Shared constants and state encoding for the slot arbiter.
package slot_arbiter_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int BURST_MAX_DEF = 4;
    localparam int IDW           = 2;

    // Requester indices: 0 is the fixed-priority video channel.
    localparam int REQ_VIDEO = 0;
    localparam int REQ_RR1   = 1;
    localparam int REQ_RR2   = 2;
    localparam int REQ_RR3   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

endpackage

// File: rtl/slot_arbiter_rr_pick.sv
// Round-robin selector over the non-video requesters.
// Bit j of req_i/gnt_o stands for requester j+1; the search starts at
// requester ptr_i and wraps from the last requester back to requester 1.
module rr_pick #(
    parameter int NRR = 3
) (
    input  logic [NRR-1:0] req_i,
    input  logic [1:0]     ptr_i,
    output logic [NRR-1:0] gnt_o,
    output logic           vld_o
);

    int start_s;
    int j_s;

    // First requesting position at or after the pointer, wrapping around.
    always_comb begin
        gnt_o   = '0;
        vld_o   = 1'b0;
        j_s     = 0;
        start_s = (ptr_i == 2'd0) ? 0 : int'(ptr_i) - 1;
        for (int k = 0; k < NRR; k++) begin
            j_s = (start_s + k) % NRR;
            if (!vld_o && req_i[j_s]) begin
                gnt_o[j_s] = 1'b1;
                vld_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slot_arbiter.sv
// Slot-based bus arbiter: video requester 0 has absolute priority, the rest
// share slots round-robin with an optional bounded burst lock. Decisions are
// made only in the c3 cycle and take effect for the whole following slot.
module slot_arbiter
    import slot_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            c0,
    input  logic            c3,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_id,
    output logic            busy,
    output logic [NREQ-1:0] ack
);

    localparam int CW = $clog2(BURST_MAX + 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      id_q, id_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q;
    logic [NREQ-1:0] ack_q;
    logic [1:0]      ph_q;

    logic [NREQ-2:0] rr_sel;
    logic            rr_vld;
    logic [1:0]      rr_id;
    logic            lock_hold;

    rr_pick #(.NRR(NREQ-1)) u_rr_pick (
        .req_i (req[NREQ-1:1]),
        .ptr_i (ptr_q),
        .gnt_o (rr_sel),
        .vld_o (rr_vld)
    );

    // Binary index of the round-robin winner (requester numbering).
    always_comb begin
        rr_id = 2'd0;
        for (int i = 0; i < NREQ-1; i++) begin
            if (rr_sel[i]) rr_id = 2'(i + 1);
        end
    end

    // Next-slot decision: video first, then burst lock, then round-robin.
    // Once the burst limit is hit the owner falls through to round-robin,
    // where the pointer already sits just past it, so any other requester
    // wins and the owner is picked again (count 1) only if it is alone.
    always_comb begin
        lock_hold = (state_q == ST_OWN) && (id_q != 2'(REQ_VIDEO)) &&
                    req[id_q] && lock[id_q] && (cnt_q < CW'(BURST_MAX));
        state_d = ST_IDLE;
        gnt_d   = '0;
        id_d    = 2'd0;
        cnt_d   = '0;
        ptr_d   = ptr_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (req[REQ_VIDEO]) begin
            state_d           = ST_OWN;
            gnt_d[REQ_VIDEO]  = 1'b1;
            id_d              = 2'(REQ_VIDEO);
        end else if (lock_hold) begin
            state_d = ST_OWN;
            gnt_d   = gnt_q;
            id_d    = id_q;
            cnt_d   = cnt_q + CW'(1);
        end else if (rr_vld) begin
            state_d = ST_OWN;
            gnt_d   = {rr_sel, 1'b0};
            id_d    = rr_id;
            cnt_d   = CW'(1);
            ptr_d   = (rr_id == 2'(NREQ-1)) ? 2'd1 : rr_id + 2'd1;
        end
    end

    // Arbitration registers, updated only at the slot boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            id_q    <= 2'd0;
            cnt_q   <= '0;
            ptr_q   <= 2'd1;
            busy_q  <= 1'b0;
        end else if (c3) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            busy_q  <= |gnt_d;
        end
    end

    // Slot phase tracker and registered ack landing in the c3 cycle.
    // ph_q reads 2 during c2, so ack_q is loaded then and shows in c3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= 2'd0;
            ack_q <= '0;
        end else begin
            ph_q  <= c0 ? 2'd1 : ph_q + 2'd1;
            ack_q <= (ph_q == 2'd2) ? gnt_q : '0;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = id_q;
    assign busy   = busy_q;
    assign ack    = ack_q;

endmodule

// File: tb/tb_slot_arbiter.sv
// Bench for slot_arbiter: free-running slot strobes, per-slot stimulus
// tables, a behavioural model compared every cycle, and literal grant logs.
module tb_slot_arbiter;

    localparam int BMAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ph = 2'd0;
    logic       c0, c3;
    logic       en = 1'b1;
    logic [3:0] req = 4'b0, lock = 4'b0;
    logic [3:0] gnt, ack;
    logic [1:0] gnt_id;
    logic       busy;

    always #5 clk = ~clk;
    always @(posedge clk) ph <= ph + 2'd1;
    assign c0 = (ph == 2'd0);
    assign c3 = (ph == 2'd3);

    slot_arbiter #(.NREQ(4), .BURST_MAX(BMAX)) dut (
        .clk(clk), .rst_n(rst_n), .c0(c0), .c3(c3), .en(en),
        .req(req), .lock(lock), .gnt(gnt), .gnt_id(gnt_id),
        .busy(busy), .ack(ack)
    );

    // Model: owner -1 = idle; cnt = slots held in current burst; ptr = next rr start.
    int         m_owner, m_cnt, m_ptr;
    logic [3:0] m_ack;
    int         n_owner, n_cnt, n_ptr;
    logic       found;

    always_comb begin
        n_owner = -1;
        n_cnt   = 0;
        n_ptr   = m_ptr;
        found   = 1'b0;
        if (!en) begin
            n_owner = -1;
        end else if (req[0]) begin
            n_owner = 0;
        end else if (m_owner >= 1 && req[m_owner] && lock[m_owner] && m_cnt < BMAX) begin
            n_owner = m_owner;
            n_cnt   = m_cnt + 1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!found && req[(m_ptr - 1 + k) % 3 + 1]) begin
                    found   = 1'b1;
                    n_owner = (m_ptr - 1 + k) % 3 + 1;
                    n_cnt   = 1;
                    n_ptr   = ((m_ptr - 1 + k) % 3 + 1) % 3 + 1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_cnt   <= 0;
            m_ptr   <= 1;
            m_ack   <= 4'b0;
        end else begin
            m_ack <= (ph == 2'd2 && m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0;
            if (ph == 2'd3) begin
                m_owner <= n_owner;
                m_cnt   <= n_cnt;
                m_ptr   <= n_ptr;
            end
        end
    end

    int   n_chk = 0, n_err = 0, ack_cnt = 0;
    logic chk_on = 1'b0;

    logic [3:0] t_req[16], t_lock[16];
    logic       t_en[16];
    int         e_id[16];

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One cycle: compare at negedge against the model, then move to #1 after next posedge.
    task automatic step();
        logic [3:0] eg;
        logic [1:0] eid;
        @(negedge clk);
        if (chk_on) begin
            eg  = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
            eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
            n_chk++;
            if (gnt !== eg || gnt_id !== eid || busy !== (m_owner >= 0) || ack !== m_ack) begin
                n_err++;
                $display("FAIL cycle t=%0t: gnt=%b id=%0d busy=%b ack=%b expected gnt=%b id=%0d busy=%b ack=%b",
                         $time, gnt, gnt_id, busy, ack, eg, eid, (m_owner >= 0), m_ack);
            end
        end
        if (ack != 4'b0) ack_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Reset during a c0 cycle; returns in the following c1 cycle.
    task automatic reset_pulse();
        while (ph != 2'd0) step();
        rst_n = 1'b0;
        req = 4'b0; lock = 4'b0; en = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_slot(input int k, input logic [3:0] r, input logic [3:0] l,
                            input logic e, input int id);
        t_req[k] = r; t_lock[k] = l; t_en[k] = e; e_id[k] = id;
    endtask

    // Apply table entries in c1 of each slot and log the owner of that slot.
    task automatic run_tab(input string nm, input int n, input int exp_acks);
        int got;
        ack_cnt = 0;
        for (int s = 0; s < n; s++) begin
            req = t_req[s]; lock = t_lock[s]; en = t_en[s];
            got = busy ? int'(gnt_id) : -1;
            chk($sformatf("%s_slot%0d", nm, s), got, e_id[s]);
            repeat (4) step();
        end
        chk($sformatf("%s_acks", nm), ack_cnt, exp_acks);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_id", int'(gnt_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk_on = 1'b1;

        // Video alone: owns every slot.
        reset_pulse();
        set_slot(0, 4'b0001, 4'b0, 1'b1, -1);
        for (int k = 1; k < 4; k++) set_slot(k, 4'b0001, 4'b0, 1'b1, 0);
        run_tab("video", 4, 3);

        // Plain round-robin among 1..3.
        reset_pulse();
        set_slot(0, 4'b1110, 4'b0, 1'b1, -1);
        for (int k = 1; k < 7; k++) set_slot(k, 4'b1110, 4'b0, 1'b1, (k - 1) % 3 + 1);
        run_tab("rr", 7, 6);

        // Burst lock on 1 capped at four slots.
        reset_pulse();
        set_slot(0, 4'b0110, 4'b0010, 1'b1, -1);
        for (int k = 1; k < 9; k++) set_slot(k, 4'b0110, 4'b0010, 1'b1, (k == 5) ? 2 : 1);
        run_tab("burst", 9, 8);

        // Video preempts a locked burst of 2; burst restarts at 1 afterwards.
        reset_pulse();
        set_slot(0, 4'b0100, 4'b0100, 1'b1, -1);
        set_slot(1, 4'b0100, 4'b0100, 1'b1, 2);
        set_slot(2, 4'b0101, 4'b0100, 1'b1, 2);
        set_slot(3, 4'b0100, 4'b0100, 1'b1, 0);
        for (int k = 4; k < 8; k++) set_slot(k, 4'b1100, 4'b0100, 1'b1, 2);
        set_slot(8, 4'b1100, 4'b0100, 1'b1, 3);
        set_slot(9, 4'b1100, 4'b0100, 1'b1, 2);
        run_tab("preempt", 10, 9);

        // en drops in c1 of a slot owned by 3.
        reset_pulse();
        set_slot(0, 4'b1000, 4'b0, 1'b1, -1);
        set_slot(1, 4'b1000, 4'b0, 1'b0, 3);
        set_slot(2, 4'b1000, 4'b0, 1'b0, -1);
        set_slot(3, 4'b1000, 4'b0, 1'b1, -1);
        set_slot(4, 4'b1000, 4'b0, 1'b1, 3);
        run_tab("en_drop", 5, 2);

        // Reset in c2 of a granted slot.
        reset_pulse();
        req = 4'b0010;
        repeat (4) step();
        chk("rst_mid_own", busy ? int'(gnt_id) : -1, 1);
        ack_cnt = 0;
        step();
        chk("rst_mid_ph", int'(ph), 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_gnt", int'(gnt), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_id", int'(gnt_id), 0);
        chk("rst_mid_ack", int'(ack), 0);
        step();
        rst_n = 1'b1;
        chk("rst_mid_noack", ack_cnt, 0);
        step();
        chk("rst_regrant_ph", int'(ph), 0);
        chk("rst_regrant_gnt", int'(gnt), 2);
        ack_cnt = 0;
        repeat (4) step();
        chk("rst_regrant_ack", ack_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/slot_arbiter.md
SLOT_ARBITER -- requirements
Module: slot_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; index 0 is the fixed-priority (video) requester.
REQ-002 Parameter BURST_MAX, default 4, maximum consecutive slots one round-robin requester keeps via lock.
REQ-003 clk  input  1  28 MHz system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 c0  input  1  phase strobe, high in first cycle of each 4-cycle slot.
REQ-006 c3  input  1  phase strobe, high in last cycle of each slot (arbitration point).
REQ-007 en  input  1  1 = new grants allowed; 0 = no new grant issued.
REQ-008 req  input  NREQ  per-requester access request, level, held until ack.
REQ-009 lock  input  NREQ  per-requester burst hold, sampled with req at arbitration point.
REQ-010 gnt  output  NREQ  one-hot grant, valid for a whole slot (c0 cycle through c3 cycle).
REQ-011 gnt_id  output  2  binary index of granted requester; 0 when idle.
REQ-012 busy  output  1  1 while any gnt bit is set.
REQ-013 ack  output  NREQ  one-cycle pulse, in c3 cycle of the granted slot, to the granted requester.

Function
REQ-014 Slot = 4 clk cycles starting at c0=1; strobes are one-hot and always cycle c0,c1,c2,c3.
REQ-015 Arbitration SHALL be evaluated only in a cycle with c3=1; result registered, gnt valid from the next (c0) cycle for exactly 4 cycles.
REQ-016 States: IDLE (gnt=0) and OWN (gnt one-hot); IDLE->OWN when arbitration selects a requester; OWN->IDLE at c3 when none selected; OWN->OWN on reselection.
REQ-017 Priority: req[0] wins whenever asserted and en=1, preempting any lock or burst.
REQ-018 Otherwise requesters 1..NREQ-1 are round-robin; search starts at index after last granted round-robin index, wrapping NREQ-1 -> 1.
REQ-019 Lock: if current owner (index>=1) has req and lock high at c3, burst count < BURST_MAX and req[0] low, owner is reselected regardless of round-robin order.
REQ-020 Burst counter: set to 1 on new owner, incremented on each lock reselection; at BURST_MAX owner is excluded for that arbitration if any other round-robin req is high, else reselected with counter reset to 1.
REQ-021 ack[i] SHALL pulse in the c3 cycle of every slot where gnt[i]=1, even if req[i] dropped mid-slot (access committed).
REQ-022 Requester keeping req high after ack is re-arbitrated in the same c3 cycle as the ack.
REQ-023 en=0: ongoing slot completes with ack; at c3 no grant issued, state goes IDLE.
REQ-024 c3 without preceding grant and no req: remain IDLE, outputs 0.
REQ-025 gnt, gnt_id, busy, ack SHALL be registered outputs; no combinational path from req to outputs.

Reset
REQ-026 rst_n low: gnt=0, gnt_id=0, busy=0, ack=0, state IDLE, burst counter 0, round-robin pointer = 1, immediately (asynchronous).
REQ-027 Reset asserted mid-slot aborts the slot with no ack; after release first grant possible only at the next c3.

Structure
REQ-028 Shared package holds NREQ default, BURST_MAX default, requester index constants (REQ_VIDEO=0 etc.) and the state encoding.
REQ-029 One sub-module, rr_pick: combinational round-robin selector (req vector, pointer -> one-hot, valid); rest is flat.

Verification
REQ-030 req=0001 held, en=1 -> gnt=0001 every slot, ack[0] pulse each c3, gnt_id=0.
REQ-031 req=1110 held, no lock, start pointer 1 -> grant order 1,2,3,1,2,3 one slot each.
REQ-032 req=0110, lock[1]=1, BURST_MAX=4 -> requester 1 owns 4 slots, then 2 owns 1 slot, then 1 again.
REQ-033 requester 2 locked in slot, req[0] rises -> next slot gnt=0001, then 2 resumes, burst count restarted at 1.
REQ-034 en drops in c1 of slot owned by 3 -> ack[3] at that c3, following slot gnt=0, busy=0.
REQ-035 rst_n low in c2 of granted slot -> outputs 0 same cycle, no ack; after release req=0010 -> grant at first c0 following a c3.
